// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle control FSM: states, ALU selects, instruction classes
// and PC source codes.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_ADDR   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_e;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_OPC   = 2'b01;
    localparam logic [1:0] ALU_BR    = 2'b10;
    localparam logic [1:0] ALU_PASS3 = 2'b11;

    localparam logic [1:0] CLASS_R  = 2'b00;
    localparam logic [1:0] CLASS_I  = 2'b01;
    localparam logic [1:0] CLASS_BR = 2'b10;
    localparam logic [1:0] CLASS_J  = 2'b11;

    localparam logic [3:0] OP_LI  = 4'b1001;
    localparam logic [3:0] OP_LWI = 4'b1011;
    localparam logic [3:0] OP_SWI = 4'b1100;

    localparam logic [1:0] PC_SRC_INC = 2'b00;
    localparam logic [1:0] PC_SRC_BR  = 2'b01;
    localparam logic [1:0] PC_SRC_JMP = 2'b10;

    localparam int unsigned WAIT_W = 8;

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational decode of the 6-bit instruction class/opcode field into class flags,
// an illegal-encoding flag and the load/store markers.
module ctrl_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [5:0] instr_op_i,
    output logic       is_r_o,
    output logic       is_i_o,
    output logic       is_br_o,
    output logic       is_j_o,
    output logic       illegal_o,
    output logic       is_lwi_o,
    output logic       is_swi_o
);

    logic [1:0] cls;
    logic [3:0] op;

    assign cls = instr_op_i[5:4];
    assign op  = instr_op_i[3:0];

    always_comb begin
        is_r_o    = 1'b0;
        is_i_o    = 1'b0;
        is_br_o   = 1'b0;
        is_j_o    = 1'b0;
        illegal_o = 1'b0;
        is_lwi_o  = 1'b0;
        is_swi_o  = 1'b0;
        unique case (cls)
            CLASS_R: begin
                is_r_o    = 1'b1;
                illegal_o = op[3];
            end
            CLASS_I: begin
                is_i_o    = 1'b1;
                // Legal I-type: arithmetic 0xxx plus LI, LWI and SWI.
                illegal_o = !(!op[3] || (op == OP_LI) || (op == OP_LWI) || (op == OP_SWI));
                is_lwi_o  = (op == OP_LWI);
                is_swi_o  = (op == OP_SWI);
            end
            CLASS_BR: begin
                is_br_o   = 1'b1;
                illegal_o = !((op == 4'b0001) || (op == 4'b0010) || (op == 4'b0011));
            end
            CLASS_J: begin
                is_j_o    = 1'b1;
                illegal_o = (op != 4'b0000);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/write-back, guards memory
// handshakes with a wait timeout and counts retired instructions.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned WORD        = 32,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [5:0]      instr_op,
    input  logic            imem_ready,
    input  logic            dmem_ready,
    input  logic            alu_zero,
    output logic [1:0]      alu_op,
    output logic [3:0]      alu_opcode,
    output logic            alu_src_imm,
    output logic            imem_req,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic            ir_write,
    output logic            pc_write,
    output logic [1:0]      pc_src,
    output logic            mar_write,
    output logic            sd_write,
    output logic            reg_write,
    output logic            mem_to_reg,
    output logic            halted,
    output logic            fault,
    output logic [WORD-1:0] instr_retired
);

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              fault_q, fault_d;
    logic [WORD-1:0]   retired_q, retired_d;
    logic              retire;

    logic is_r, is_i, is_br, is_j, illegal, is_lwi, is_swi;

    ctrl_decode u_decode (
        .instr_op_i (instr_op),
        .is_r_o     (is_r),
        .is_i_o     (is_i),
        .is_br_o    (is_br),
        .is_j_o     (is_j),
        .illegal_o  (illegal),
        .is_lwi_o   (is_lwi),
        .is_swi_o   (is_swi)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            fault_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            fault_q   <= fault_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_d      = '0;
        fault_d     = fault_q;
        retire      = 1'b0;
        alu_op      = ALU_ADD;
        alu_opcode  = 4'b0000;
        alu_src_imm = 1'b0;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = PC_SRC_INC;
        mar_write   = 1'b0;
        sd_write    = 1'b0;
        reg_write   = 1'b0;
        mem_to_reg  = 1'b0;
        halted      = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                // Ready on the limit cycle still wins over the timeout.
                if (imem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (wait_q == WAIT_LIMIT) begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DECODE: begin
                state_d = illegal ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                if (is_r) begin
                    alu_op     = ALU_OPC;
                    alu_opcode = instr_op[3:0];
                    state_d    = S_WB;
                end else if (is_i) begin
                    if (is_lwi) begin
                        state_d = S_ADDR;
                    end else if (is_swi) begin
                        alu_op     = ALU_OPC;
                        alu_opcode = OP_SWI;
                        sd_write   = 1'b1;
                        state_d    = S_ADDR;
                    end else begin
                        alu_op      = ALU_OPC;
                        alu_opcode  = instr_op[3:0];
                        alu_src_imm = 1'b1;
                        state_d     = S_WB;
                    end
                end else if (is_br) begin
                    alu_op     = ALU_BR;
                    alu_opcode = instr_op[3:0];
                    if (alu_zero) begin
                        pc_write = 1'b1;
                        pc_src   = PC_SRC_BR;
                    end
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (is_j) begin
                    pc_write = 1'b1;
                    pc_src   = PC_SRC_JMP;
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    state_d = S_HALT;
                end
            end
            S_ADDR: begin
                alu_op      = ALU_PASS3;
                alu_opcode  = instr_op[3:0];
                alu_src_imm = 1'b1;
                mar_write   = 1'b1;
                state_d     = S_MEM;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_swi;
                if (dmem_ready) begin
                    if (is_swi) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_q == WAIT_LIMIT) begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = is_lwi;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    assign retired_d     = retired_q + {{(WORD-1){1'b0}}, retire};
    assign fault         = fault_q;
    assign instr_retired = retired_q;

endmodule
